// File: rtl/controle_multiciclo_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit.
package controle_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    // Operation class handed from the FSM to the ALU decoder.
    typedef enum logic [1:0] {
        ACLS_ADD = 2'd0,
        ACLS_SUB = 2'd1,
        ACLS_R   = 2'd2,
        ACLS_I   = 2'd3
    } alu_cls_e;

    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/controle_multiciclo_if.sv
// Control-unit <-> datapath bundle. `illegal` exists only with CONTROLE_ILLEGAL_TRAP_EN.
interface controle_multiciclo_if #(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned ALUCTL_W = 4
);
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic                funct7_5;
    logic                zero;
    logic                mem_ready;
    logic                pc_write;
    logic                ir_write;
    logic                iord;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                mem_to_reg;
    logic [1:0]          alu_src_a;
    logic [1:0]          alu_src_b;
    logic [ALUCTL_W-1:0] alu_control;
    logic                pc_src;
    logic                instr_done;
    logic [CNT_W-1:0]    retired;
    logic [2:0]          state;
`ifdef CONTROLE_ILLEGAL_TRAP_EN
    logic                illegal;
`endif

    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_src,
               instr_done, retired, state
`ifdef CONTROLE_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  pc_write, ir_write, iord, mem_read, mem_write, reg_write,
               mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_src,
               instr_done, retired, state
`ifdef CONTROLE_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );
endinterface

// File: rtl/controle_multiciclo_alu_decoder.sv
// Maps operation class plus funct fields to the ALU control code.
module alu_decoder
    import controle_pkg::*;
#(
    parameter int unsigned ALUCTL_W = 4
) (
    input  alu_cls_e            cls_i,
    input  logic [2:0]          funct3_i,
    input  logic                funct7_5_i,
    output logic [ALUCTL_W-1:0] alu_control_o
);
    logic [3:0] code;

    always_comb begin
        code = ALU_ADD;
        case (cls_i)
            ACLS_SUB: code = ALU_SUB;
            ACLS_R, ACLS_I: begin
                case (funct3_i)
                    3'b000:  code = (cls_i == ACLS_R && funct7_5_i) ? ALU_SUB : ALU_ADD;
                    3'b111:  code = ALU_AND;
                    3'b110:  code = ALU_OR;
                    3'b100:  code = ALU_XOR;
                    3'b001:  code = ALU_SLL;
                    3'b101:  code = ALU_SRL;
                    default: code = ALU_ADD;
                endcase
            end
            default: code = ALU_ADD;
        endcase
        alu_control_o = ALUCTL_W'(code);
    end
endmodule

// File: rtl/controle_multiciclo.sv
// Multi-cycle RV32I control FSM with retired-instruction counter.
// Optional CONTROLE_ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned ALUCTL_W = 4
) (
    input logic                  clk,
    input logic                  rst,
    controle_multiciclo_if.master bus
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q;
    alu_cls_e         alu_cls;
    logic             done_c;
    logic             known_op;
    logic             br_taken;

    alu_decoder #(.ALUCTL_W(ALUCTL_W)) u_alu_dec (
        .cls_i         (alu_cls),
        .funct3_i      (bus.funct3),
        .funct7_5_i    (bus.funct7_5),
        .alu_control_o (bus.alu_control)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (done_c) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign known_op = (bus.opcode == OP_LW) || (bus.opcode == OP_SW) || (bus.opcode == OP_R)
                   || (bus.opcode == OP_I)  || (bus.opcode == OP_BR);
    assign br_taken = (bus.funct3 == 3'b000 &&  bus.zero)
                   || (bus.funct3 == 3'b001 && !bus.zero);

    // Strobes decode the registered state; everything is quiet while rst is high.
    always_comb begin
        state_d        = state_q;
        done_c         = 1'b0;
        alu_cls        = ACLS_ADD;
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = SRCA_PC;
        bus.alu_src_b  = SRCB_RS2;
        bus.pc_src     = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.alu_src_b = SRCB_FOUR;
                    if (bus.mem_ready) begin
                        bus.ir_write = 1'b1;
                        bus.pc_write = 1'b1;
                        state_d      = S_DECODE;
                    end
                end
                S_DECODE: begin
                    bus.alu_src_a = SRCA_OLDPC;
                    bus.alu_src_b = SRCB_IMM;
                    if (known_op) begin
                        state_d = S_EXEC;
                    end else begin
`ifdef CONTROLE_ILLEGAL_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d = S_FETCH;
                        done_c  = 1'b1;
`endif
                    end
                end
                S_EXEC: begin
                    bus.alu_src_a = SRCA_RS1;
                    state_d       = S_FETCH;
                    case (bus.opcode)
                        OP_LW, OP_SW: begin
                            bus.alu_src_b = SRCB_IMM;
                            state_d       = S_MEM;
                        end
                        OP_R: begin
                            alu_cls = ACLS_R;
                            state_d = S_WB;
                        end
                        OP_I: begin
                            bus.alu_src_b = SRCB_IMM;
                            alu_cls       = ACLS_I;
                            state_d       = S_WB;
                        end
                        OP_BR: begin
                            alu_cls      = ACLS_SUB;
                            bus.pc_write = br_taken;
                            bus.pc_src   = br_taken;
                            done_c       = 1'b1;
                        end
                        default: state_d = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    bus.iord = 1'b1;
                    if (bus.opcode == OP_SW) begin
                        bus.mem_write = 1'b1;
                        if (bus.mem_ready) begin
                            done_c  = 1'b1;
                            state_d = S_FETCH;
                        end
                    end else begin
                        bus.mem_read = 1'b1;
                        if (bus.mem_ready) state_d = S_WB;
                    end
                end
                S_WB: begin
                    bus.reg_write  = 1'b1;
                    bus.mem_to_reg = (bus.opcode == OP_LW);
                    done_c         = 1'b1;
                    state_d        = S_FETCH;
                end
`ifdef CONTROLE_ILLEGAL_TRAP_EN
                S_TRAP:  state_d = S_TRAP;
`endif
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign bus.instr_done = done_c;
    assign bus.retired    = retired_q;
    assign bus.state      = 3'(state_q);
`ifdef CONTROLE_ILLEGAL_TRAP_EN
    assign bus.illegal    = !rst && (state_q == S_TRAP);
`endif
endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench: per-cycle expected outputs queued at drive time, checked at the falling edge.
module tb_controle_multiciclo;
    import controle_pkg::*;

    typedef struct packed {
        logic [2:0]  st;
        logic        pcw, irw, iord, mr, mw, rw, m2r;
        logic [1:0]  sa, sb;
        logic [3:0]  ac;
        logic        ps, done;
        logic [31:0] ret;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    controle_multiciclo_if bus ();

    controle_multiciclo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] ret_m  = '0;

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                          input logic z, input logic rdy);
        bus.opcode    = op;
        bus.funct3    = f3;
        bus.funct7_5  = f75;
        bus.zero      = z;
        bus.mem_ready = rdy;
    endtask

    function automatic exp_t f_idle(input logic [2:0] st);
        exp_t e;
        e     = '0;
        e.st  = st;
        e.ac  = ALU_ADD;
        e.ret = ret_m;
        return e;
    endfunction

    function automatic exp_t f_fetch(input logic rdy);
        exp_t e;
        e     = f_idle(3'd0);
        e.mr  = 1'b1;
        e.sb  = SRCB_FOUR;
        e.irw = rdy;
        e.pcw = rdy;
        return e;
    endfunction

    function automatic exp_t f_dec(input logic done);
        exp_t e;
        e      = f_idle(3'd1);
        e.sa   = SRCA_OLDPC;
        e.sb   = SRCB_IMM;
        e.done = done;
        return e;
    endfunction

    function automatic exp_t f_exe(input logic [1:0] sb, input logic [3:0] ac,
                                   input logic taken, input logic done);
        exp_t e;
        e      = f_idle(3'd2);
        e.sa   = SRCA_RS1;
        e.sb   = sb;
        e.ac   = ac;
        e.pcw  = taken;
        e.ps   = taken;
        e.done = done;
        return e;
    endfunction

    function automatic exp_t f_mem(input logic is_sw, input logic rdy);
        exp_t e;
        e      = f_idle(3'd3);
        e.iord = 1'b1;
        e.mr   = !is_sw;
        e.mw   = is_sw;
        e.done = is_sw && rdy;
        return e;
    endfunction

    function automatic exp_t f_wb(input logic lw);
        exp_t e;
        e      = f_idle(3'd4);
        e.rw   = 1'b1;
        e.m2r  = lw;
        e.done = 1'b1;
        return e;
    endfunction

    // Queue the expectation, pop and compare at the falling edge, advance past the next rising edge.
    task automatic step(input string tag, input exp_t e);
        exp_t obs, exp_v;
        sb_q.push_back(e);
        @(negedge clk);
        obs.st   = bus.state;
        obs.pcw  = bus.pc_write;
        obs.irw  = bus.ir_write;
        obs.iord = bus.iord;
        obs.mr   = bus.mem_read;
        obs.mw   = bus.mem_write;
        obs.rw   = bus.reg_write;
        obs.m2r  = bus.mem_to_reg;
        obs.sa   = bus.alu_src_a;
        obs.sb   = bus.alu_src_b;
        obs.ac   = bus.alu_control;
        obs.ps   = bus.pc_src;
        obs.done = bus.instr_done;
        obs.ret  = bus.retired;
`ifdef CONTROLE_ILLEGAL_TRAP_EN
        obs.ill  = bus.illegal;
`else
        obs.ill  = 1'b0;
`endif
        exp_v = sb_q.pop_front();
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
        @(posedge clk);
        if (rst) ret_m = '0;
        else if (exp_v.done) ret_m = ret_m + 32'd1;
        #1;
    endtask

    logic [2:0] r_f3[5];
    logic [3:0] r_ac[5];

    initial begin
        exp_t e;
        r_f3 = '{3'b111, 3'b110, 3'b001, 3'b101, 3'b000};
        r_ac = '{ALU_AND, ALU_OR, ALU_SLL, ALU_SRL, ALU_ADD};

        set_in(7'h00, 3'b000, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        step("reset0", f_idle(3'd0));
        step("reset1", f_idle(3'd0));
        rst = 1'b0;

        // R-type sub
        set_in(OP_R, 3'b000, 1'b1, 1'b0, 1'b1);
        step("sub_fetch", f_fetch(1'b1));
        step("sub_dec",   f_dec(1'b0));
        step("sub_exec",  f_exe(SRCB_RS2, ALU_SUB, 1'b0, 1'b0));
        step("sub_wb",    f_wb(1'b0));

        // LW with three memory wait cycles
        set_in(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        step("lw_fetch", f_fetch(1'b1));
        step("lw_dec",   f_dec(1'b0));
        step("lw_exec",  f_exe(SRCB_IMM, ALU_ADD, 1'b0, 1'b0));
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("lw_mem_wait", f_mem(1'b0, 1'b0));
        bus.mem_ready = 1'b1;
        step("lw_mem_rdy", f_mem(1'b0, 1'b1));
        step("lw_wb",      f_wb(1'b1));

        // beq and bne with zero=1
        set_in(OP_BR, 3'b000, 1'b0, 1'b1, 1'b1);
        step("beq_fetch", f_fetch(1'b1));
        step("beq_dec",   f_dec(1'b0));
        step("beq_exec",  f_exe(SRCB_RS2, ALU_SUB, 1'b1, 1'b1));
        set_in(OP_BR, 3'b001, 1'b0, 1'b1, 1'b1);
        step("bne_fetch", f_fetch(1'b1));
        step("bne_dec",   f_dec(1'b0));
        step("bne_exec",  f_exe(SRCB_RS2, ALU_SUB, 1'b0, 1'b1));

        // SW with a fetch wait and a memory wait
        set_in(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0);
        step("sw_fetch_wait", f_fetch(1'b0));
        bus.mem_ready = 1'b1;
        step("sw_fetch", f_fetch(1'b1));
        step("sw_dec",   f_dec(1'b0));
        step("sw_exec",  f_exe(SRCB_IMM, ALU_ADD, 1'b0, 1'b0));
        bus.mem_ready = 1'b0;
        step("sw_mem_wait", f_mem(1'b1, 1'b0));
        bus.mem_ready = 1'b1;
        step("sw_mem_rdy",  f_mem(1'b1, 1'b1));

        // xori, then addi with instruction[30] set
        set_in(OP_I, 3'b100, 1'b0, 1'b0, 1'b1);
        step("xori_fetch", f_fetch(1'b1));
        step("xori_dec",   f_dec(1'b0));
        step("xori_exec",  f_exe(SRCB_IMM, ALU_XOR, 1'b0, 1'b0));
        step("xori_wb",    f_wb(1'b0));
        set_in(OP_I, 3'b000, 1'b1, 1'b0, 1'b1);
        step("addi_fetch", f_fetch(1'b1));
        step("addi_dec",   f_dec(1'b0));
        step("addi_exec",  f_exe(SRCB_IMM, ALU_ADD, 1'b0, 1'b0));
        step("addi_wb",    f_wb(1'b0));

        // Remaining R-type operations
        for (int k = 0; k < 5; k++) begin
            set_in(OP_R, r_f3[k], 1'b0, 1'b0, 1'b1);
            step("r_fetch", f_fetch(1'b1));
            step("r_dec",   f_dec(1'b0));
            step("r_exec",  f_exe(SRCB_RS2, r_ac[k], 1'b0, 1'b0));
            step("r_wb",    f_wb(1'b0));
        end

        // Reset while LW waits in MEM
        set_in(OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        step("abort_fetch", f_fetch(1'b1));
        step("abort_dec",   f_dec(1'b0));
        step("abort_exec",  f_exe(SRCB_IMM, ALU_ADD, 1'b0, 1'b0));
        bus.mem_ready = 1'b0;
        step("abort_mem", f_mem(1'b0, 1'b0));
        bus.mem_ready = 1'b1;
        rst = 1'b1;
        step("abort_rst",  f_idle(3'd3));
        step("abort_next", f_idle(3'd0));
        rst = 1'b0;

        // Unknown opcode
        set_in(7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1);
        step("ill_fetch", f_fetch(1'b1));
`ifdef CONTROLE_ILLEGAL_TRAP_EN
        step("ill_dec", f_dec(1'b0));
        e     = f_idle(3'd5);
        e.ill = 1'b1;
        step("ill_trap0", e);
        step("ill_trap1", e);
        rst = 1'b1;
        step("ill_trap_rst", f_idle(3'd5));
        rst = 1'b0;
`else
        step("ill_dec_nop", f_dec(1'b1));
`endif
        step("post_fetch", f_fetch(1'b1));

        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: observed %0d left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
